muldiv_unit: RTL and testbench

Iterative, parametrised multiply/divide unit that produces a double-width HI/LO result for the CPU datapath's HI and LO registers. It supports signed and unsigned MUL and DIV with a start/busy/done handshake. It replaces single-cycle multiply/divide in the ALU path with a WIDTH-cycle radix-2 engine: shift-add for multiply, restoring division for divide. The control unit stalls on busy and loads HI/LO when done pulses.

---
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with a start/busy/done handshake.
// MUL uses shift-add and DIV uses restoring division; sign fix-up is applied in a final cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {StIdle, StPrep, StRun, StFix} state_e;

  state_e               state_q, state_d;
  logic [1:0]           op_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 neg_res_q, neg_rem_q, zdiv_q;

  logic                 sgn_op, div_op, neg_a, neg_b, zero_div;
  logic [WIDTH-1:0]     mag_a, mag_b, addend;
  logic [WIDTH:0]       mul_sum, div_rem, div_trial;
  logic [2*WIDTH-1:0]   step;
  logic [WIDTH-1:0]     hi_fix, lo_fix;

  assign sgn_op   = op_q[0];
  assign div_op   = op_q[1];
  assign neg_a    = sgn_op & a_q[WIDTH-1];
  assign neg_b    = sgn_op & b_q[WIDTH-1];
  assign zero_div = div_op && (b_q == '0);

  // |MIN| = 2^(WIDTH-1) still fits in an unsigned WIDTH-bit magnitude.
  assign mag_a = neg_a ? -a_q : a_q;
  assign mag_b = neg_b ? -b_q : b_q;

  assign addend    = prod_q[0] ? mcand_q : '0;
  assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign div_rem   = prod_q[2*WIDTH-1:WIDTH-1];
  assign div_trial = div_rem - {1'b0, mcand_q};

  always_comb begin
    step = prod_q;
    if (div_op) begin
      if (div_trial[WIDTH]) begin
        step = {div_rem[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
      end else begin
        step = {div_trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      step = {mul_sum, prod_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    hi_fix = prod_q[2*WIDTH-1:WIDTH];
    lo_fix = prod_q[WIDTH-1:0];
    if (zdiv_q) begin
      hi_fix = a_q;
      lo_fix = '1;
    end else if (div_op) begin
      lo_fix = neg_res_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
      hi_fix = neg_rem_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
    end else if (neg_res_q) begin
      {hi_fix, lo_fix} = -prod_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StPrep;
      StPrep:  state_d = zero_div ? StFix : StRun;
      StRun:   if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      zdiv_q      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q        <= op;
            a_q         <= a;
            b_q         <= b;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
          end
        end
        StPrep: begin
          cnt_q     <= '0;
          zdiv_q    <= zero_div;
          neg_res_q <= neg_a ^ neg_b;
          // The remainder follows the dividend; the product follows both operands.
          neg_rem_q <= div_op ? neg_a : (neg_a ^ neg_b);
          if (div_op) begin
            prod_q  <= {{WIDTH{1'b0}}, mag_a};
            mcand_q <= mag_b;
          end else begin
            prod_q  <= {{WIDTH{1'b0}}, mag_b};
            mcand_q <= mag_a;
          end
        end
        StRun: begin
          prod_q <= step;
          cnt_q  <= cnt_q + CNT_W'(1);
        end
        StFix: begin
          hi          <= hi_fix;
          lo          <= lo_fix;
          div_by_zero <= zdiv_q;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;
  localparam int unsigned W = 32;

  logic       clock = 1'b0;
  logic       clear;
  logic       start, start8;
  logic [1:0] op, op8;
  logic [W-1:0] a, b, hi, lo;
  logic [7:0] a8, b8, hi8, lo8;
  logic       busy, done, div_by_zero, busy8, done8, dbz8;
  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  muldiv_unit #(.WIDTH(32)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clock(clock), .clear(clear), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_by_zero(dbz8)
  );

  task automatic check_eq(input string tag, input longint unsigned got,
                          input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic on sign- or zero-extended operands.
  function automatic void ref_op(input int w, input logic [1:0] o,
                                 input longint unsigned x, input longint unsigned y,
                                 output longint unsigned rh, output longint unsigned rl,
                                 output logic rz);
    longint unsigned mask, up;
    longint sx, sy, p;
    mask = (64'd1 << w) - 64'd1;
    sx = $signed(x << (64 - w)) >>> (64 - w);
    sy = $signed(y << (64 - w)) >>> (64 - w);
    rz = 1'b0;
    rh = 0;
    rl = 0;
    if (o[1] && y == 0) begin
      rz = 1'b1;
      rh = x;
      rl = mask;
    end else begin
      case (o)
        2'd0: begin up = x * y; rh = (up >> w) & mask; rl = up & mask; end
        2'd1: begin p = sx * sy; up = p; rh = (up >> w) & mask; rl = up & mask; end
        2'd2: begin rl = (x / y) & mask; rh = (x % y) & mask; end
        default: begin p = sx / sy; rl = p & mask; p = sx % sy; rh = p & mask; end
      endcase
    end
  endfunction

  // Starts an op from an idle cycle, optionally pokes start mid-run, and checks the result.
  task automatic run32(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit poke);
    longint unsigned eh, el;
    logic ez;
    int n, nb;
    bit seen;
    ref_op(W, o, x, y, eh, el, ez);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check_eq("accept_busy", busy, 1);
    check_eq("start_clears_dbz", div_by_zero, 0);
    op = 2'($urandom); a = $urandom; b = $urandom;
    nb = 1; n = 0; seen = 0;
    for (int i = 1; i <= 200 && !seen; i++) begin
      if (poke && i == 5) start = 1'b1;
      if (poke && i == 6) start = 1'b0;
      @(posedge clock); #1;
      if (done) begin
        seen = 1; n = i;
      end else if (busy) begin
        nb++;
      end
    end
    check_eq("latency", n, ez ? 2 : W + 2);
    check_eq("busy_cycles", nb, ez ? 2 : W + 2);
    check_eq("busy_at_done", busy, 0);
    check_eq("hi", hi, eh);
    check_eq("lo", lo, el);
    check_eq("div_by_zero", div_by_zero, ez);
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    longint unsigned eh, el;
    logic ez;
    int n;
    ref_op(8, o, x, y, eh, el, ez);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clock); #1;
    start8 = 1'b0;
    n = 0;
    for (int i = 1; i <= 50 && n == 0; i++) begin
      @(posedge clock); #1;
      if (done8) n = i;
    end
    check_eq("w8_latency", n, ez ? 2 : 10);
    check_eq("w8_hi", hi8, eh);
    check_eq("w8_lo", lo8, el);
    check_eq("w8_dbz", dbz8, ez);
  endtask

  function automatic logic [W-1:0] pick32();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int stray;
    clear = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_hi", hi, 0);
    check_eq("rst_lo", lo, 0);
    check_eq("rst_dbz", div_by_zero, 0);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;

    run32(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check_eq("t1_hi", hi, 32'hFFFF_FFFE);
    check_eq("t1_lo", lo, 32'h0000_0001);
    run32(2'd1, 32'hFFFF_FFFD, 32'd7, 0);
    check_eq("t2_mul_hi", hi, 32'hFFFF_FFFF);
    check_eq("t2_mul_lo", lo, 32'hFFFF_FFEB);
    run32(2'd0, 32'hFFFF_FFFD, 32'd7, 0);
    check_eq("t2_mulu_hi", hi, 32'h0000_0006);
    check_eq("t2_mulu_lo", lo, 32'hFFFF_FFEB);
    run32(2'd3, 32'hFFFF_FFF9, 32'd2, 0);
    check_eq("t3_div_lo", lo, 32'hFFFF_FFFD);
    check_eq("t3_div_hi", hi, 32'hFFFF_FFFF);
    run32(2'd2, 32'd100, 32'd7, 0);
    check_eq("t3_divu_lo", lo, 32'd14);
    check_eq("t3_divu_hi", hi, 32'd2);
    repeat (3) @(posedge clock);
    #1;
    check_eq("hold_done", done, 0);
    check_eq("hold_lo", lo, 32'd14);
    run32(2'd2, 32'd5, 32'd0, 0);
    check_eq("t4_lo", lo, 32'hFFFF_FFFF);
    check_eq("t4_hi", hi, 32'd5);
    check_eq("t4_dbz", div_by_zero, 1);
    run32(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check_eq("t5_lo", lo, 32'h8000_0000);
    check_eq("t5_hi", hi, 32'd0);
    // Issued on the done cycle of the previous op.
    run32(2'd1, 32'h1234_5678, 32'h8765_4321, 0);
    run32(2'd0, 32'h0001_2345, 32'h0000_6789, 1);

    for (int k = 0; k < 40; k++) begin
      run32(2'($urandom_range(0, 3)), pick32(), pick32(), bit'($urandom_range(0, 1)));
    end

    run32(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    op = 2'd1; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    clear = 1'b0;
    #1;
    check_eq("clr_busy", busy, 0);
    check_eq("clr_done", done, 0);
    check_eq("clr_hi", hi, 0);
    check_eq("clr_lo", lo, 0);
    @(negedge clock);
    clear = 1'b1;
    stray = 0;
    repeat (50) begin
      @(posedge clock); #1;
      if (done || busy) stray++;
    end
    check_eq("no_done_after_clear", stray, 0);
    run32(2'd3, 32'hFFFF_FF9C, 32'd7, 0);

    run8(2'd0, 8'hFF, 8'hFF);
    check_eq("w8_t1_hi", hi8, 8'hFE);
    check_eq("w8_t1_lo", lo8, 8'h01);
    for (int k = 0; k < 20; k++) begin
      run8(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
